seq_decoder: RTL

SEQ_DECODER -- requirements
Module: seq_decoder

---
 rtl/asip_decode_pkg.sv | 39 +++
 rtl/decode_table.sv | 44 ++++
 rtl/seq_decoder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/asip_decode_pkg.sv
// Shared decode definitions: opcode encodings, writeback sources, FSM states
// and the decoded-control bundle produced by the opcode table.
package asip_decode_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'hC;
  localparam logic [3:0] OP_STORE = 4'hD;
  localparam logic [3:0] OP_LOADI = 4'hE;
  localparam logic [3:0] OP_RSVD  = 4'hF;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_IMM = 2'b10
  } wb_src_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCALAR = 2'd1,
    ST_VECTOR = 2'd2
  } state_e;

  typedef struct packed {
    logic       mem_write;
    logic [2:0] exec_op;
    wb_src_e    wb_src;
    logic       ovr_nz;
    logic       reg_we_sc;
    logic       reg_we_vec;
    logic       is_vector;
    logic       illegal;
  } dec_ctrl_t;

  // Opcodes 1000-1011 are the vector ALU group.
  function automatic logic is_vector_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/decode_table.sv
// Combinational opcode-to-control lookup; no state.
module decode_table
  import asip_decode_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_ctrl_t  ctrl
);

  always_comb begin
    ctrl        = '0;
    ctrl.wb_src = WB_ALU;
    case (opcode)
      OP_NOP: begin
        ctrl.exec_op = 3'b000;
      end
      OP_LOAD: begin
        ctrl.reg_we_sc = 1'b1;
        ctrl.wb_src    = WB_MEM;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
      end
      OP_LOADI: begin
        ctrl.reg_we_sc = 1'b1;
        ctrl.wb_src    = WB_IMM;
      end
      OP_RSVD: begin
        ctrl.illegal = 1'b1;
      end
      default: begin
        if (is_vector_op(opcode)) begin
          ctrl.exec_op    = {1'b0, opcode[1:0]};
          ctrl.reg_we_vec = 1'b1;
          ctrl.is_vector  = 1'b1;
        end else begin
          ctrl.exec_op   = opcode[2:0];
          ctrl.reg_we_sc = 1'b1;
          ctrl.ovr_nz    = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/seq_decoder.sv
// Sequencing instruction decoder: accepts one instruction, presents one beat
// per lane group for vector ops and a single beat otherwise.
module seq_decoder
  import asip_decode_pkg::*;
#(
  parameter int INSTR_W     = 16,
  parameter int IMM_W       = 8,
  parameter int NUM_LANES   = 8,
  parameter int ISSUE_LANES = 4,
  localparam int BEATS      = NUM_LANES / ISSUE_LANES,
  localparam int LG_W       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               MemoryWrite,
  output logic [2:0]         ExecuteOp,
  output logic [1:0]         WriteRegFrom,
  output logic               OverwriteNZ,
  output logic [3:0]         RegToWrite,
  output logic [IMM_W-1:0]   Immediate,
  output logic               RegWriteEnSc,
  output logic               RegWriteEnVec,
  output logic [LG_W-1:0]    lane_group,
  output logic               out_last,
  output logic               illegal_instr
);

  localparam logic [LG_W-1:0] LAST_LG = LG_W'(BEATS - 1);

  logic [3:0]       opcode;
  logic [3:0]       rd;
  logic [IMM_W-1:0] imm;
  dec_ctrl_t        dec;

  assign opcode = instruction[INSTR_W-1 -: 4];
  assign rd     = instruction[INSTR_W-5 -: 4];
  assign imm    = instruction[IMM_W-1:0];

  decode_table u_decode_table (
    .opcode (opcode),
    .ctrl   (dec)
  );

  state_e           state_q, state_d;
  logic [LG_W-1:0]  lane_q, lane_d;
  logic             mem_write_q, mem_write_d;
  logic [2:0]       exec_op_q, exec_op_d;
  wb_src_e          wb_q, wb_d;
  logic             nz_q, nz_d;
  logic [3:0]       rd_q, rd_d;
  logic [IMM_W-1:0] imm_q, imm_d;
  logic             we_sc_q, we_sc_d;
  logic             we_vec_q, we_vec_d;
  logic             illegal_q, illegal_d;

  logic accept;
  logic consume;

  assign out_valid = (state_q != ST_IDLE);
  assign out_last  = (state_q == ST_SCALAR) ||
                     ((state_q == ST_VECTOR) && (lane_q == LAST_LG));
  assign in_ready  = !rst && !flush && (!out_valid || (out_ready && out_last));
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    mem_write_d = mem_write_q;
    exec_op_d   = exec_op_q;
    wb_d        = wb_q;
    nz_d        = nz_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    we_sc_d     = we_sc_q;
    we_vec_d    = we_vec_q;
    illegal_d   = 1'b0;

    if (flush) begin
      state_d = ST_IDLE;
      lane_d  = '0;
    end else begin
      if (consume) begin
        if (out_last) begin
          state_d = ST_IDLE;
          lane_d  = '0;
        end else begin
          lane_d = lane_q + LG_W'(1);
        end
      end
      // A reserved opcode only raises the pulse; the held beat fields stay put.
      if (accept) begin
        if (dec.illegal) begin
          illegal_d = 1'b1;
        end else begin
          state_d     = dec.is_vector ? ST_VECTOR : ST_SCALAR;
          lane_d      = '0;
          mem_write_d = dec.mem_write;
          exec_op_d   = dec.exec_op;
          wb_d        = dec.wb_src;
          nz_d        = dec.ovr_nz;
          rd_d        = rd;
          imm_d       = imm;
          we_sc_d     = dec.reg_we_sc;
          we_vec_d    = dec.reg_we_vec;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      mem_write_q <= 1'b0;
      exec_op_q   <= '0;
      wb_q        <= WB_ALU;
      nz_q        <= 1'b0;
      rd_q        <= '0;
      imm_q       <= '0;
      we_sc_q     <= 1'b0;
      we_vec_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      mem_write_q <= mem_write_d;
      exec_op_q   <= exec_op_d;
      wb_q        <= wb_d;
      nz_q        <= nz_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      we_sc_q     <= we_sc_d;
      we_vec_q    <= we_vec_d;
      illegal_q   <= illegal_d;
    end
  end

  assign MemoryWrite   = mem_write_q;
  assign ExecuteOp     = exec_op_q;
  assign WriteRegFrom  = wb_q;
  assign OverwriteNZ   = nz_q;
  assign RegToWrite    = rd_q;
  assign Immediate     = imm_q;
  assign RegWriteEnSc  = we_sc_q;
  assign RegWriteEnVec = we_vec_q;
  assign lane_group    = lane_q;
  assign illegal_instr = illegal_q;

endmodule
